// File: rtl/code_pkg.sv
// Shared definitions for the safe-lock button interface: button symbols,
// sender FSM states and the symbol-to-line decoder.
package code_pkg;

    typedef enum logic [1:0] {
        SYM_BLANK = 2'b00,
        SYM_A     = 2'b01,
        SYM_B     = 2'b10,
        SYM_C     = 2'b11
    } sym_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_WAIT_UNLK,
        ST_FINISH
    } sender_state_t;

    // Returns the line pattern {A,B,C}; at most one line is ever high.
    function automatic logic [2:0] decode(input sym_t s);
        logic [2:0] abc;
        unique case (s)
            SYM_A:   abc = 3'b100;
            SYM_B:   abc = 3'b010;
            SYM_C:   abc = 3'b001;
            default: abc = 3'b000;
        endcase
        return abc;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero; zero flags the end of an interval.
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/code_sender.sv
// Transmitter for the safe-lock button interface: plays a latched symbol
// sequence onto A/B/C, then reports whether the lock opened.
module code_sender
    import code_pkg::*;
#(
    parameter int MAX_LEN  = 8,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [2*MAX_LEN-1:0]           code,
    input  logic [$clog2(MAX_LEN+1)-1:0]   code_len,
    input  logic                           unlock_in,
    output logic                           A,
    output logic                           B,
    output logic                           C,
    output logic                           busy,
    output logic                           done,
    output logic                           success
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int TMAX = max3(HOLD_CYC, GAP_CYC, TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    sender_state_t        state, state_nxt;
    logic [2*MAX_LEN-1:0] code_q, code_src;
    logic [LW-1:0]        len_q, idx, idx_nxt;
    logic                 sticky, sticky_nxt, succ_nxt;
    logic                 busy_nxt, done_nxt;
    logic [2:0]           abc_nxt;
    logic                 tmr_load, tmr_zero;
    logic [TW-1:0]        tmr_val;
    sym_t                 sym;

    cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // The first symbol is decoded in the start cycle, before code is latched.
    assign code_src = (state == ST_IDLE) ? code : code_q;
    assign sym      = sym_t'(code_src[2*idx_nxt +: 2]);

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        sticky_nxt = sticky;
        succ_nxt   = success;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    idx_nxt    = '0;
                    sticky_nxt = 1'b0;
                    succ_nxt   = 1'b0;
                    state_nxt  = (code_len != '0) ? ST_PRESS : ST_FINISH;
                end
            end
            ST_PRESS: begin
                if (unlock_in) sticky_nxt = 1'b1;
                if (tmr_zero) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (unlock_in) sticky_nxt = 1'b1;
                if (tmr_zero) begin
                    if ((idx + LW'(1)) < len_q) begin
                        idx_nxt   = idx + LW'(1);
                        state_nxt = ST_PRESS;
                    end else begin
                        state_nxt = ST_WAIT_UNLK;
                    end
                end
            end
            ST_WAIT_UNLK: begin
                if (sticky || unlock_in) begin
                    succ_nxt  = 1'b1;
                    state_nxt = ST_FINISH;
                end else if (tmr_zero) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so lines change on the entry edge.
    always_comb begin
        abc_nxt  = (state_nxt == ST_PRESS) ? decode(sym) : 3'b000;
        busy_nxt = (state_nxt == ST_PRESS) || (state_nxt == ST_GAP) ||
                   (state_nxt == ST_WAIT_UNLK);
        done_nxt = (state_nxt == ST_FINISH);
        tmr_load = (state_nxt != state);
        unique case (state_nxt)
            ST_PRESS:     tmr_val = TW'(HOLD_CYC - 1);
            ST_GAP:       tmr_val = TW'(GAP_CYC - 1);
            ST_WAIT_UNLK: tmr_val = TW'(TIMEOUT - 1);
            default:      tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            sticky  <= 1'b0;
            success <= 1'b0;
            A       <= 1'b0;
            B       <= 1'b0;
            C       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            sticky      <= sticky_nxt;
            success     <= succ_nxt;
            {A, B, C}   <= abc_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // A length above MAX_LEN is clamped so the symbol index stays inside code.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            code_q <= code;
            len_q  <= (code_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : code_len;
        end
    end

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender: a timeline model queues the expected
// per-cycle line/status trace of each transaction and the DUT is compared against it.
module tb_code_sender;

    localparam int MAX_LEN  = 8;
    localparam int HOLD_CYC = 4;
    localparam int GAP_CYC  = 2;
    localparam int TIMEOUT  = 16;

    typedef struct packed {
        logic [2:0] abc;
        logic       busy;
        logic       done;
        logic       success;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] code;
    logic [3:0]  code_len;
    logic        unlock_in;
    logic        A, B, C, busy, done, success;

    exp_t exp_q[$];
    int   ncomp = 0;
    int   nfail = 0;

    code_sender #(
        .MAX_LEN  (MAX_LEN),
        .HOLD_CYC (HOLD_CYC),
        .GAP_CYC  (GAP_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .code      (code),
        .code_len  (code_len),
        .unlock_in (unlock_in),
        .A         (A),
        .B         (B),
        .C         (C),
        .busy      (busy),
        .done      (done),
        .success   (success)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] lines_of(input logic [1:0] s);
        case (s)
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic void push(input logic [2:0] abc, input logic bz,
                                 input logic dn, input logic sc);
        exp_t e;
        e.abc     = abc;
        e.busy    = bz;
        e.done    = dn;
        e.success = sc;
        exp_q.push_back(e);
    endfunction

    // Expected trace from cycle 1 (first cycle after start is sampled),
    // given the cycle uc on which unlock_in is pulsed (-1 for never).
    function automatic void build(input logic [15:0] c, input int len, input int uc);
        int   t;
        logic stk, sc;
        exp_q.delete();
        t   = 1;
        stk = 1'b0;
        sc  = 1'b0;
        if (len > 0) begin
            for (int i = 0; i < len; i++) begin
                for (int h = 0; h < HOLD_CYC; h++) begin
                    push(lines_of(c[2*i +: 2]), 1'b1, 1'b0, 1'b0);
                    if (t == uc) stk = 1'b1;
                    t++;
                end
                for (int g = 0; g < GAP_CYC; g++) begin
                    push(3'b000, 1'b1, 1'b0, 1'b0);
                    if (t == uc) stk = 1'b1;
                    t++;
                end
            end
            for (int w = 0; w < TIMEOUT; w++) begin
                push(3'b000, 1'b1, 1'b0, 1'b0);
                if (stk || t == uc) begin
                    sc = 1'b1;
                    break;
                end
                t++;
            end
        end
        push(3'b000, 1'b0, 1'b1, sc);
        push(3'b000, 1'b0, 1'b0, sc);
    endfunction

    task automatic check(input string tag, input int t, input logic [5:0] obs,
                         input logic [5:0] expv);
        ncomp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s cycle %0d: got {ABC,busy,done,success}=%b expected %b",
                   tag, t, obs, expv);
        end
    endtask

    task automatic kick(input logic [15:0] c, input int len);
        @(negedge clk);
        code     = c;
        code_len = 4'(len);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Pops the queued trace one cycle at a time; stops early after cycle stop_at when >0.
    task automatic play(input string tag, input int uc, input bit disturb, input int stop_at);
        exp_t e;
        int   t;
        t = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            unlock_in = (t == uc);
            e = exp_q.pop_front();
            check(tag, t, {A, B, C, busy, done, success}, e);
            if (disturb && t == 3) begin
                start    = 1'b1;
                code     = 16'hFFFF;
                code_len = 4'd1;
            end
            if (disturb && t == 6) start = 1'b0;
            if (stop_at > 0 && t == stop_at) break;
            t++;
        end
        unlock_in = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        code      = '0;
        code_len  = '0;
        unlock_in = 1'b0;

        repeat (3) @(negedge clk);
        check("reset", 0, {A, B, C, busy, done, success}, 6'b000000);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle", 0, {A, B, C, busy, done, success}, 6'b000000);

        // Correct code A,A,B; lock opens in the first wait cycle.
        build(16'h0025, 3, 19);
        kick(16'h0025, 3);
        play("aab_unlock", 19, 1'b0, 0);

        // Wrong code A,B,A: no unlock, ends on timeout.
        build(16'h0019, 3, -1);
        kick(16'h0019, 3);
        play("aba_timeout", -1, 1'b0, 0);

        // Zero length: immediate done, lines and busy never rise.
        build(16'h0025, 0, -1);
        kick(16'h0025, 0);
        play("len0", -1, 1'b0, 0);

        // Re-start and code change mid-transaction must be ignored.
        build(16'h0025, 3, 19);
        kick(16'h0025, 3);
        play("disturbed", 19, 1'b1, 0);

        // Reset during the second press window.
        build(16'h0025, 3, 19);
        kick(16'h0025, 3);
        play("pre_reset", 19, 1'b0, 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 8, {A, B, C, busy, done, success}, 6'b000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", 9 + i, {A, B, C, busy, done, success}, 6'b000000);
        end
        rst_n = 1'b1;
        build(16'h0025, 3, 19);
        kick(16'h0025, 3);
        play("after_reset", 19, 1'b0, 0);

        // Blank middle symbol; unlock seen during the B press is kept.
        build(16'h0021, 3, 14);
        kick(16'h0021, 3);
        play("blank_sticky", 14, 1'b0, 0);

        // Full-length code with every symbol kind; unlock mid-wait.
        build(16'hE4E4, 8, 54);
        kick(16'hE4E4, 8);
        play("len8_all", 54, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
